// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, a sequential bulk clear, and saturating event counters.
// Latency: reads are combinational; writes become visible one cycle after the edge (same cycle with RF_BYPASS_EN).
// Backpressure: none; writes that arrive during a clear are dropped and counted, and clr_busy reports the clear.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   we_a/wa_a/wd_a             write port A
//   we_b/wa_b/wd_b             write port B; wins a same-address collision
//   ra / rd                    NRD packed read ports; port i uses ra[i*ADDR_W +: ADDR_W] and rd[i*DATA_W +: DATA_W]
//   clr_req / clr_busy         one-cycle pulse that starts a bulk clear / high while the clear runs
//   write_count, conflict_count, drop_count   saturating event counters
//   rf_status                  registered status: 01 clear, 11 collision, 10 write, 00 idle
// Optional macro RF_BYPASS_EN forwards same-cycle write data to the read ports.
// CNT_W must be at least 2.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_a,
  input  logic [ADDR_W-1:0]     wa_a,
  input  logic [DATA_W-1:0]     wd_a,
  input  logic                  we_b,
  input  logic [ADDR_W-1:0]     wa_b,
  input  logic [DATA_W-1:0]     wd_b,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic [CNT_W-1:0]      write_count,
  output logic [CNT_W-1:0]      conflict_count,
  output logic [CNT_W-1:0]      drop_count,
  output logic [1:0]            rf_status
);

  localparam int NUM_REGS = 2**ADDR_W;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0]   rf_q [NUM_REGS];
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    cf_cnt_q, cf_cnt_d;
  logic [CNT_W-1:0]    dr_cnt_q, dr_cnt_d;
  logic [1:0]          status_q, status_d;

  logic                idle;
  logic                a_ok, b_ok, collide;
  logic                commit_a, commit_b;
  logic [1:0]          wr_inc, dr_inc;

  // Add 0..2 to a counter, clamping at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, v} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) return '1;
    return sum[CNT_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Write qualification
  // ---------------------------------------------------------------------------
  assign idle    = (state_q == ST_IDLE);
  assign a_ok    = idle && we_a && (wa_a != '0);
  assign b_ok    = idle && we_b && (wa_b != '0);
  assign collide = a_ok && b_ok && (wa_a == wa_b);
  // On a collision only B commits, so the pair counts as a single write.
  assign commit_a = a_ok && !collide;
  assign commit_b = b_ok;

  assign wr_inc = {1'b0, commit_a} + {1'b0, commit_b};
  // In CLEAR every enabled port is dropped; in IDLE only writes to address 0.
  assign dr_inc = idle ? ({1'b0, we_a && (wa_a == '0)} + {1'b0, we_b && (wa_b == '0)})
                       : ({1'b0, we_a} + {1'b0, we_b});

  // ---------------------------------------------------------------------------
  // Clear FSM and status, next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_idx_d = ADDR_W'(1);  // register 0 is already constant zero
        end
      end
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (&clr_idx_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    status_d = 2'b00;
    if (!idle || clr_req)        status_d = 2'b01;
    else if (collide)            status_d = 2'b11;
    else if (commit_a || commit_b) status_d = 2'b10;
  end

  always_comb begin
    wr_cnt_d = sat_add(wr_cnt_q, wr_inc);
    cf_cnt_d = sat_add(cf_cnt_q, {1'b0, collide});
    dr_cnt_d = sat_add(dr_cnt_q, dr_inc);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
      wr_cnt_q  <= '0;
      cf_cnt_q  <= '0;
      dr_cnt_q  <= '0;
      status_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wr_cnt_q  <= wr_cnt_d;
      cf_cnt_q  <= cf_cnt_d;
      dr_cnt_q  <= dr_cnt_d;
      status_q  <= status_d;
    end
  end

  // Register array. Entry 0 is only ever written by reset, so it stays zero.
  // B is written after A so a collision leaves B's data, though commit_a
  // already excludes that case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (!idle) begin
      rf_q[clr_idx_q] <= '0;
    end else begin
      if (commit_a) rf_q[wa_a] <= wd_a;
      if (commit_b) rf_q[wa_b] <= wd_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra_p;
    logic [DATA_W-1:0] rd_p;

    assign ra_p = ra[p*ADDR_W +: ADDR_W];

    always_comb begin
      rd_p = rf_q[ra_p];
`ifdef RF_BYPASS_EN
      // Forward data that commits on the coming edge; B first, as in commit.
      if (idle && (ra_p != '0)) begin
        if (we_b && (wa_b == ra_p))      rd_p = wd_b;
        else if (we_a && (wa_a == ra_p)) rd_p = wd_a;
      end
`endif
      if (ra_p == '0) rd_p = '0;
    end

    assign rd[p*DATA_W +: DATA_W] = rd_p;
  end

  assign clr_busy       = (state_q == ST_CLEAR);
  assign write_count    = wr_cnt_q;
  assign conflict_count = cf_cnt_q;
  assign drop_count     = dr_cnt_q;
  assign rf_status      = status_q;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the MIPS pipeline datapath. It provides configurable data width, depth and read-port count, and two synchronous write ports with defined collision priority. It also has a sequential bulk-clear engine and saturating event counters. Register 0 is hardwired to zero.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W
NRD, 2, number of combinational read ports (1..4)
CNT_W, 16, width of each event counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
we_a  in  1  write enable, port A
wa_a  in  ADDR_W  write address, port A
wd_a  in  DATA_W  write data, port A
we_b  in  1  write enable, port B (priority port)
wa_b  in  ADDR_W  write address, port B
wd_b  in  DATA_W  write data, port B
ra  in  NRD*ADDR_W  packed read addresses; port i uses slice [i*ADDR_W +: ADDR_W]
rd  out  NRD*DATA_W  packed read data; port i uses slice [i*DATA_W +: DATA_W]
clr_req  in  1  single-cycle pulse that starts a bulk clear
clr_busy  out  1  high while a bulk clear is in progress
write_count  out  CNT_W  committed writes, saturating
conflict_count  out  CNT_W  same-address A/B collisions, saturating
drop_count  out  CNT_W  writes discarded (address 0 or during clear), saturating
rf_status  out  2  registered status code

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0; all counters 0; FSM IDLE; clr_busy 0; rf_status 2'b00. rd is combinational, so it reads 0.
- Read: rd port i is a combinational read of rf[ra_i]. Address 0 always returns 0. No bypass by default: a same-cycle write becomes visible the cycle after the edge.
- Write on a rising edge in IDLE:
  - Each enabled port with a nonzero address commits and increments write_count by 1.
  - A, B or both enabled to address 0 increments drop_count once per port.
  - Both enabled to the same nonzero address: B's data is stored, write_count +1, conflict_count +1.
  - Both enabled to different nonzero addresses: both commit, write_count +2.
- Counters saturate at 2**CNT_W-1 and never wrap. Simultaneous increments of +2 near the top clamp to the max value.
- FSM has two states, IDLE and CLEAR:
  - IDLE→CLEAR: when clr_req=1 in IDLE. The clear index loads 1. clr_busy goes high the next cycle.
  - In CLEAR: one register per cycle, rf[idx] <= 0 and idx++. All writes on A and B are discarded, and each enabled port increments drop_count. Reads return current contents, which are partially cleared.
  - CLEAR→IDLE: after the cycle that clears index NUM_REGS-1. Total busy time is NUM_REGS-1 cycles. clr_busy drops on the edge that leaves CLEAR.
  - clr_req while in CLEAR is ignored; there is no restart.
  - Reset mid-clear returns to IDLE with all registers 0.
- rf_status is registered each edge, highest-priority condition first:
  - 2'b01: in CLEAR or entering CLEAR
  - 2'b11: a collision occurred this edge
  - 2'b10: any write committed
  - 2'b00: otherwise
- Address ranges are exact (NUM_REGS = 2**ADDR_W), so there are no out-of-range addresses and no error path.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: each read port forwards same-cycle write data when ra_i matches an enabled write address in IDLE and ra_i != 0. B has priority over A, matching the commit rule. No forwarding during CLEAR.
- Undefined: plain array read as above. Write data is visible only from the next cycle.

Test Plan:
- Reset then read all addresses on both ports -> all rd 0; all counters 0; rf_status 00; clr_busy 0.
- we_a=1, wa_a=5, wd_a=32'hDEAD_BEEF; next cycle ra0=5 -> rd0=32'hDEAD_BEEF; write_count=1; rf_status=10. Same-cycle read: 0 without RF_BYPASS_EN, 32'hDEAD_BEEF with it.
- we_a=we_b=1, both addresses 7, wd_a=1, wd_b=2 -> rf[7]=2; write_count=1; conflict_count=1; rf_status=11.
- we_a=1, wa_a=0, wd_a=32'hFFFF_FFFF -> rd for address 0 stays 0; drop_count=1; write_count unchanged.
- Preload regs 1..31 with nonzero values, pulse clr_req, issue we_a every cycle -> clr_busy high exactly 31 cycles; all regs 0 afterwards; drop_count=31; clr_req during busy has no effect.
- With CNT_W=2, issue 5 dual-port writes to distinct addresses -> write_count holds at 3 with no wrap. Assert rst_n low mid-clear -> immediate clr_busy=0 and all regs 0.
